// File: rtl/de_scoreboard_pkg.sv
// Shared sizing constants and types for the decode-stage register-hazard scoreboard.
package de_scoreboard_pkg;

  localparam int REGWORDS  = 32;
  localparam int REGNOBITS = 5;
  localparam int MAX_INFL  = 3;
  localparam int CNT_BITS  = 2;
  localparam bit WB_BYPASS = 1'b1;

  typedef logic [REGNOBITS-1:0] reg_idx_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(MAX_INFL);

  // True when a qualified register access targets register idx.
  function automatic logic reg_hit(input logic valid, input reg_idx_t a, input reg_idx_t idx);
    return valid && (a == idx);
  endfunction

endpackage

// File: rtl/de_scoreboard_if.sv
// Decode / squash / writeback inputs and hazard outputs of the scoreboard.
interface de_scoreboard_if;
  import de_scoreboard_pkg::*;

  logic                issue_valid_i;
  reg_idx_t            rs1_i;
  reg_idx_t            rs2_i;
  logic                rs1_rd_i;
  logic                rs2_rd_i;
  logic                wr_reg_i;
  reg_idx_t            rd_i;
  logic                squash_i;
  logic                wb_valid_i;
  reg_idx_t            wb_rd_i;
  logic                stall_o;
  logic                issue_fire_o;
  logic [REGWORDS-1:0] busy_bits_o;
  logic [31:0]         stall_cnt_o;
  logic                underflow_err_o;

  modport master (
    output issue_valid_i, rs1_i, rs2_i, rs1_rd_i, rs2_rd_i, wr_reg_i, rd_i,
           squash_i, wb_valid_i, wb_rd_i,
    input  stall_o, issue_fire_o, busy_bits_o, stall_cnt_o, underflow_err_o
  );

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, rs1_rd_i, rs2_rd_i, wr_reg_i, rd_i,
           squash_i, wb_valid_i, wb_rd_i,
    output stall_o, issue_fire_o, busy_bits_o, stall_cnt_o, underflow_err_o
  );

endinterface

// File: rtl/sb_reg_counter.sv
// In-flight write counter for one architectural register.
module sb_reg_counter
  import de_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic wb_hit,
  output cnt_t count,
  output logic busy,
  output logic underflow
);

  logic dec;

  assign dec       = wb_hit && (count != '0);
  assign underflow = wb_hit && (count == '0);
  assign busy      = (count != '0);

  // NOTE: state is updated with non-blocking assignments so every counter
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + cnt_t'(1);
    end else if (dec && !inc) begin
      count <= count - cnt_t'(1);
    end
  end

endmodule

// File: rtl/de_scoreboard.sv
// Register-hazard scheduler: per-register in-flight write counts decide DE issue vs stall.
module de_scoreboard
  import de_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  de_scoreboard_if.slave  sb
);

  cnt_t [REGWORDS-1:1] count;
  logic [REGWORDS-1:1] busy;
  logic [REGWORDS-1:1] underflow_hit;
  logic [REGWORDS-1:1] inc_vec;
  logic [REGWORDS-1:1] wb_hit_vec;
  logic [REGWORDS-1:0] ready_vec;
  logic [REGWORDS-1:0] full_vec;

  logic        stall;
  logic        fire;
  logic        waw_block;
  logic [31:0] stall_cnt;
  logic        underflow_err;

  // NOTE: every always_comb output gets a default before the loop, so no
  // path can leave a bit unassigned and infer a latch.
  always_comb begin
    wb_hit_vec   = '0;
    ready_vec    = '0;
    full_vec     = '0;
    ready_vec[0] = 1'b1;
    for (int r = 1; r < REGWORDS; r++) begin
      wb_hit_vec[r] = reg_hit(sb.wb_valid_i, sb.wb_rd_i, reg_idx_t'(r));
      ready_vec[r]  = (count[r] == '0) ||
                      (WB_BYPASS && (count[r] == cnt_t'(1)) && wb_hit_vec[r]);
      full_vec[r]   = (count[r] == CNT_MAX);
    end
  end

  // A full destination may still issue if one of its writes retires this cycle.
  assign waw_block = sb.wr_reg_i && full_vec[sb.rd_i] &&
                     !reg_hit(sb.wb_valid_i, sb.wb_rd_i, sb.rd_i);

  assign stall = sb.issue_valid_i && !sb.squash_i &&
                 ((sb.rs1_rd_i && !ready_vec[sb.rs1_i]) ||
                  (sb.rs2_rd_i && !ready_vec[sb.rs2_i]) ||
                  waw_block);

  assign fire = sb.issue_valid_i && !sb.squash_i && !stall;

  always_comb begin
    inc_vec = '0;
    for (int r = 1; r < REGWORDS; r++) begin
      inc_vec[r] = fire && reg_hit(sb.wr_reg_i, sb.rd_i, reg_idx_t'(r));
    end
  end

  for (genvar r = 1; r < REGWORDS; r++) begin : g_cnt
    sb_reg_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_vec[r]),
      .wb_hit    (wb_hit_vec[r]),
      .count     (count[r]),
      .busy      (busy[r]),
      .underflow (underflow_hit[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (|underflow_hit) begin
        underflow_err <= 1'b1;
      end
    end
  end

  assign sb.stall_o         = stall;
  assign sb.issue_fire_o    = fire;
  assign sb.busy_bits_o     = {busy, 1'b0};
  assign sb.stall_cnt_o     = stall_cnt;
  assign sb.underflow_err_o = underflow_err;

endmodule

// File: tb/tb_de_scoreboard.sv
// Self-checking bench for de_scoreboard: per-register count model feeding an expectation queue.
module tb_de_scoreboard;
  import de_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  de_scoreboard_if sb ();

  de_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mcnt[REGWORDS];
  logic [31:0] m_stall_cnt;
  logic        m_uf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0x%0h expected none at %0t", obs, $time);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic drv(input logic v, input int rs1, input logic r1, input int rs2, input logic r2,
                     input logic wr, input int rd, input logic sq, input logic wbv, input int wbrd);
    sb.issue_valid_i = v;
    sb.rs1_i         = reg_idx_t'(rs1);
    sb.rs1_rd_i      = r1;
    sb.rs2_i         = reg_idx_t'(rs2);
    sb.rs2_rd_i      = r2;
    sb.wr_reg_i      = wr;
    sb.rd_i          = reg_idx_t'(rd);
    sb.squash_i      = sq;
    sb.wb_valid_i    = wbv;
    sb.wb_rd_i       = reg_idx_t'(wbrd);
  endtask

  task automatic idle_wb(input logic wbv, input int wbrd);
    drv(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, wbv, wbrd);
  endtask

  function automatic logic m_ready(input int r);
    int wr_r;
    wr_r = int'(sb.wb_rd_i);
    return (r == 0) || (mcnt[r] == 0) ||
           (mcnt[r] == 1 && sb.wb_valid_i && wr_r == r);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < REGWORDS; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < REGWORDS; r++) mcnt[r] = 0;
    m_stall_cnt = '0;
    m_uf        = 1'b0;
  endtask

  // Inputs already driven after a negedge; checks combinational then registered outputs.
  task automatic cycle();
    logic ms, mf;
    int   rd, wbrd;
    #1;
    rd   = int'(sb.rd_i);
    wbrd = int'(sb.wb_rd_i);
    ms = sb.issue_valid_i && !sb.squash_i &&
         ((sb.rs1_rd_i && !m_ready(int'(sb.rs1_i))) ||
          (sb.rs2_rd_i && !m_ready(int'(sb.rs2_i))) ||
          (sb.wr_reg_i && rd != 0 && mcnt[rd] == MAX_INFL && !(sb.wb_valid_i && wbrd == rd)));
    mf = sb.issue_valid_i && !sb.squash_i && !ms;
    exp_q.push_back('{"stall_o", 32'(ms)});
    exp_q.push_back('{"issue_fire_o", 32'(mf)});
    pop_check(32'(sb.stall_o));
    pop_check(32'(sb.issue_fire_o));

    if (sb.wb_valid_i && wbrd != 0) begin
      if (mcnt[wbrd] == 0) m_uf = 1'b1;
      else mcnt[wbrd]--;
    end
    if (mf && sb.wr_reg_i && rd != 0) mcnt[rd]++;
    if (ms && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    exp_q.push_back('{"busy_bits_o", m_busy()});
    exp_q.push_back('{"stall_cnt_o", m_stall_cnt});
    exp_q.push_back('{"underflow_err_o", 32'(m_uf)});

    @(posedge clk);
    #1;
    pop_check(sb.busy_bits_o);
    pop_check(sb.stall_cnt_o);
    pop_check(32'(sb.underflow_err_o));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pend[$];
    int guard;

    reset = 1'b1;
    idle_wb(1'b0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_busy", sb.busy_bits_o, 32'h0);
    check("reset_stall_cnt", sb.stall_cnt_o, 32'h0);
    check("reset_underflow", 32'(sb.underflow_err_o), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // RAW hazard on x5, released by bypassed writeback
    drv(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0, 0);
    cycle();
    check("t1_busy5", 32'(sb.busy_bits_o[5]), 32'h1);
    drv(1'b1, 5, 1'b1, 1, 1'b1, 1'b1, 6, 1'b0, 1'b0, 0);
    #1 check("t1_stall", 32'(sb.stall_o), 32'h1);
    cycle();
    cycle();
    drv(1'b1, 5, 1'b1, 1, 1'b1, 1'b1, 6, 1'b0, 1'b1, 5);
    #1 check("t1_fire_in_wb", 32'(sb.issue_fire_o), 32'h1);
    cycle();
    idle_wb(1'b1, 6);
    cycle();

    // WAW saturation on x7
    repeat (3) begin
      drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 0);
      cycle();
    end
    #1 check("t2_stall_full", 32'(sb.stall_o), 32'h1);
    cycle();
    drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0, 1'b1, 7);
    #1 check("t2_fire_with_wb", 32'(sb.issue_fire_o), 32'h1);
    cycle();
    repeat (3) begin
      idle_wb(1'b1, 7);
      cycle();
    end
    check("t2_drained", sb.busy_bits_o, 32'h0);

    // squash dominates stall
    drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 0);
    cycle();
    drv(1'b1, 8, 1'b1, 0, 1'b0, 1'b1, 9, 1'b1, 1'b0, 0);
    #1 check("t3_stall", 32'(sb.stall_o), 32'h0);
    check("t3_fire", 32'(sb.issue_fire_o), 32'h0);
    cycle();
    check("t3_counts", sb.busy_bits_o, 32'h0000_0100);
    idle_wb(1'b1, 8);
    cycle();

    // x0 ignored; writeback to idle register is sticky error
    drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
    cycle();
    idle_wb(1'b1, 0);
    cycle();
    check("t4_x0_busy", sb.busy_bits_o, 32'h0);
    check("t4_x0_uf", 32'(sb.underflow_err_o), 32'h0);
    idle_wb(1'b1, 9);
    cycle();
    check("t4_uf_set", 32'(sb.underflow_err_o), 32'h1);
    idle_wb(1'b0, 0);
    repeat (3) cycle();
    check("t4_uf_sticky", 32'(sb.underflow_err_o), 32'h1);

    // asynchronous reset with writes in flight
    repeat (2) begin
      drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 0);
      cycle();
    end
    idle_wb(1'b0, 0);
    #2 reset = 1'b1;
    #1;
    check("t5_busy_async", sb.busy_bits_o, 32'h0);
    check("t5_stall_cnt_async", sb.stall_cnt_o, 32'h0);
    check("t5_uf_async", 32'(sb.underflow_err_o), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drv(1'b1, 3, 1'b1, 3, 1'b1, 1'b1, 4, 1'b0, 1'b0, 0);
    #1 check("t5_no_stall", 32'(sb.stall_o), 32'h0);
    cycle();
    idle_wb(1'b1, 4);
    cycle();

    // ten stall cycles
    drv(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 0);
    cycle();
    drv(1'b1, 10, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    repeat (10) cycle();
    check("t6_stall_cnt10", sb.stall_cnt_o, 32'd10);
    drv(1'b1, 10, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 10);
    cycle();

    // random issue / writeback stream
    for (int n = 0; n < 400; n++) begin
      int wbrd;
      logic wbv;
      pend.delete();
      for (int r = 1; r < 8; r++) if (mcnt[r] != 0) pend.push_back(r);
      wbv  = (pend.size() != 0) && ($urandom_range(0, 2) != 0);
      wbrd = wbv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      drv(1'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 7) == 0), wbv, wbrd);
      cycle();
    end
    guard = 0;
    for (int r = 1; r < 8; r++) begin
      while (mcnt[r] != 0 && guard < 64) begin
        idle_wb(1'b1, r);
        cycle();
        guard++;
      end
    end
    check("t6_final_busy", sb.busy_bits_o, 32'h0);
    check("t6_no_underflow", 32'(sb.underflow_err_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
